i2c_target_regfile: RTL and testbench

- I2C target (slave) block: the responder to i2c_master_top. Runs on the system clock, oversamples SCL/SDA and exposes a byte-addressed register file to the bus.
- The first byte of a write sets the register pointer; subsequent write bytes store at the pointer. Reads return bytes from the pointer. The pointer auto-increments and wraps.
- Used as a synthesizable on-chip target and as the clocked replacement bus model in master benches.

---
 rtl/i2c_target_regfile.sv | 188 ++++++++++++++++++
 tb/tb_i2c_target_regfile.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/i2c_target_regfile.sv
// i2c_target_regfile: I2C target that exposes a byte-addressed register file.
// The first write byte after the address loads the register pointer. Each later
// write byte is stored at the pointer. Reads return bytes starting at the
// pointer. The pointer auto-increments and wraps.
// Ports:
//   clk       system clock; all logic changes on the rising edge
//   reset     synchronous, active-low reset
//   SCL       bus clock from the master (this target never stretches it)
//   SDA       open-drain bus data; pulled low only while sda_oe=1
//   busy      set on an address match, cleared by STOP or by an address mismatch
//   wr_strobe one-cycle pulse for each data byte written to the register file
//   wr_addr   register address of that write (valid with wr_strobe)
//   wr_data   byte written (valid with wr_strobe)
module i2c_target_regfile #(
  parameter logic [6:0] SLAVE_ADDR = 7'b0000010,
  parameter int          MEM_AW     = 8          // at most 8: the pointer byte carries it
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              SCL,
  inout  wire               SDA,
  output logic              busy,
  output logic              wr_strobe,
  output logic [MEM_AW-1:0] wr_addr,
  output logic [7:0]        wr_data
);
  localparam int DEPTH = 2**MEM_AW;

  typedef enum logic [2:0] {IDLE, ADDR, MEMADDR, WRITE, READ, MACK, WAIT_STOP} state_t;

  state_t            state, state_n;
  logic              scl_s1, scl_s2, scl_prev;
  logic              sda_s1, sda_s2, sda_prev;
  logic              scl_rise_q, scl_fall_q, start_q, stop_q, sda_q;
  logic [3:0]        cnt, cnt_n;
  logic [7:0]        shift, shift_n;
  logic [MEM_AW-1:0] ptr, ptr_n;
  logic              sda_oe, sda_oe_n, busy_n, rw, rw_n, mem_we;
  logic [7:0]        mem [DEPTH];
  logic [7:0]        rx_byte, rd_byte;

  assign SDA = sda_oe ? 1'b0 : 1'bz;

  // The byte as it stands once the bit sampled on this scl_rise is shifted in.
  assign rx_byte = {shift[6:0], sda_q};
  assign rd_byte = mem[ptr];

  // Synchronizers and bus-event detection. The events are registered once more
  // before the FSM uses them. This makes SDA change 4 clk after the SCL pin falls.
  // The sync flops reset to 1, the idle level of the bus.
  always_ff @(posedge clk) begin
    if (!reset) begin
      scl_s1 <= 1'b1; scl_s2 <= 1'b1; scl_prev <= 1'b1;
      sda_s1 <= 1'b1; sda_s2 <= 1'b1; sda_prev <= 1'b1;
      scl_rise_q <= 1'b0; scl_fall_q <= 1'b0;
      start_q <= 1'b0; stop_q <= 1'b0; sda_q <= 1'b1;
    end else begin
      scl_s1 <= SCL;    scl_s2 <= scl_s1; scl_prev <= scl_s2;
      sda_s1 <= SDA;    sda_s2 <= sda_s1; sda_prev <= sda_s2;
      scl_rise_q <= scl_s2 & ~scl_prev;
      scl_fall_q <= ~scl_s2 & scl_prev;
      start_q    <= scl_s2 & sda_prev & ~sda_s2;
      stop_q     <= scl_s2 & ~sda_prev & sda_s2;
      sda_q      <= sda_s2;
    end
  end

  // cnt counts SCL rises within the current 9-clock frame: 0..7 are data bits,
  // 8 means the 8th bit is done and the ACK slot is next, 9 means inside the ACK slot.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    shift_n  = shift;
    ptr_n    = ptr;
    sda_oe_n = sda_oe;
    busy_n   = busy;
    rw_n     = rw;
    mem_we   = 1'b0;
    if (stop_q) begin
      state_n  = IDLE;
      busy_n   = 1'b0;
      sda_oe_n = 1'b0;
    end else if (start_q) begin
      state_n  = ADDR;
      cnt_n    = 4'd0;
      sda_oe_n = 1'b0;
    end else begin
      case (state)
        ADDR, MEMADDR, WRITE: begin
          if (scl_rise_q) begin
            if (cnt < 4'd8) begin
              shift_n = rx_byte;
              cnt_n   = cnt + 4'd1;
            end else begin
              cnt_n = 4'd9;
            end
            if (cnt == 4'd7) begin
              case (state)
                ADDR: begin
                  if (rx_byte[7:1] == SLAVE_ADDR) begin
                    busy_n = 1'b1;
                    rw_n   = rx_byte[0];
                  end else begin
                    busy_n  = 1'b0;
                    state_n = IDLE;   // do not ACK; ignore the bus until the next START
                  end
                end
                MEMADDR: ptr_n = rx_byte[MEM_AW-1:0];
                default: begin
                  mem_we = 1'b1;
                  ptr_n  = ptr + MEM_AW'(1);
                end
              endcase
            end
          end else if (scl_fall_q) begin
            if (cnt == 4'd8) begin
              sda_oe_n = 1'b1;        // ACK
            end else if (cnt == 4'd9) begin
              cnt_n = 4'd0;
              if (state == ADDR && rw) begin
                state_n  = READ;
                sda_oe_n = ~rd_byte[7];
                shift_n  = {rd_byte[6:0], 1'b0};
              end else begin
                sda_oe_n = 1'b0;
                state_n  = (state == ADDR) ? MEMADDR : WRITE;
              end
            end
          end
        end
        READ: begin
          if (scl_rise_q) begin
            cnt_n = cnt + 4'd1;
            if (cnt == 4'd7) begin
              ptr_n   = ptr + MEM_AW'(1);
              state_n = MACK;
            end
          end else if (scl_fall_q) begin
            sda_oe_n = ~shift[7];
            shift_n  = {shift[6:0], 1'b0};
          end
        end
        MACK: begin
          if (scl_fall_q && cnt == 4'd8) begin
            sda_oe_n = 1'b0;          // hand SDA to the master for its ACK/NACK
          end else if (scl_rise_q && cnt == 4'd8) begin
            cnt_n = 4'd9;
            if (sda_q) state_n = WAIT_STOP;
          end else if (scl_fall_q && cnt == 4'd9) begin
            cnt_n    = 4'd0;
            state_n  = READ;
            sda_oe_n = ~rd_byte[7];
            shift_n  = {rd_byte[6:0], 1'b0};
          end
        end
        default: ;                    // IDLE, WAIT_STOP: only START/STOP move on
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0; shift <= '0; ptr <= '0; sda_oe <= 1'b0; busy <= 1'b0; rw <= 1'b0;
      wr_strobe <= 1'b0; wr_addr <= '0; wr_data <= '0;
    end else begin
      cnt <= cnt_n; shift <= shift_n; ptr <= ptr_n; sda_oe <= sda_oe_n;
      busy <= busy_n; rw <= rw_n;
      wr_strobe <= mem_we;
      if (mem_we) begin
        wr_addr <= ptr;
        wr_data <= rx_byte;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 8'h00;
    end else if (mem_we) begin
      mem[ptr] <= rx_byte;
    end
  end
endmodule

// File: tb/tb_i2c_target_regfile.sv
// Directed bench for i2c_target_regfile. A bit-banged bus master drives SCL/SDA
// with 10-clk SCL phases. A reference register file and pointer model produce
// the expected write strobes and read bytes. The expected values are queued
// when a byte is sent and compared when the target produces them.
module tb_i2c_target_regfile;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;     // 1 = master releases SDA
  wire        sda_bus;
  logic       busy, wr_strobe;
  logic [7:0] wr_addr, wr_data;

  typedef struct packed {logic [7:0] addr; logic [7:0] data;} wr_t;

  wr_t        wr_q[$];
  logic [7:0] rd_q[$];
  logic [7:0] model [256];
  logic [7:0] mptr;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  assign sda_bus = sda_m ? 1'bz : 1'b0;
  pullup (sda_bus);

  i2c_target_regfile #(.SLAVE_ADDR(7'b0000010), .MEM_AW(8)) dut (
    .clk(clk), .reset(reset), .SCL(scl_m), .SDA(sda_bus),
    .busy(busy), .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Every write strobe is compared against the oldest expected write.
  // If a strobe arrives with nothing queued, the compare fails.
  always @(negedge clk) begin
    logic [16:0] exp_v;
    wr_t         e;
    if (wr_strobe) begin
      exp_v = '0;
      if (wr_q.size() > 0) begin
        e     = wr_q.pop_front();
        exp_v = {1'b1, e};
      end
      chk("wr_strobe", {15'd0, 1'b1, wr_addr, wr_data}, {15'd0, exp_v});
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // START and repeated START. This is entered with SCL low, or with the bus idle.
  task automatic start_c();
    sda_m = 1'b1; tick(5); scl_m = 1'b1; tick(10);
    sda_m = 1'b0; tick(10); scl_m = 1'b0; tick(5);
  endtask

  task automatic stop_c();
    sda_m = 1'b0; tick(5); scl_m = 1'b1; tick(10); sda_m = 1'b1; tick(10);
  endtask

  task automatic put_bit(input logic b);
    sda_m = b; tick(5); scl_m = 1'b1; tick(10); scl_m = 1'b0; tick(5);
  endtask

  task automatic get_bit(output logic b);
    sda_m = 1'b1; tick(5); scl_m = 1'b1; tick(5); b = sda_bus; tick(5); scl_m = 1'b0; tick(5);
  endtask

  // exp_ack: 0 = the target must ACK, 1 = no ACK (SDA stays high).
  task automatic send_byte(input logic [7:0] d, input logic exp_ack, input string tag);
    logic a;
    for (int i = 7; i >= 0; i--) put_bit(d[i]);
    get_bit(a);
    chk(tag, {31'd0, a}, {31'd0, exp_ack});
  endtask

  task automatic set_ptr(input logic [7:0] p);
    start_c();
    send_byte(8'h04, 1'b0, "ack_addr_w");
    send_byte(p, 1'b0, "ack_ptr");
    mptr = p;
  endtask

  task automatic write_data(input logic [7:0] d);
    wr_q.push_back('{addr: mptr, data: d});
    model[mptr] = d;
    mptr = mptr + 8'd1;
    send_byte(d, 1'b0, "ack_data");
  endtask

  task automatic read_start();
    start_c();
    send_byte(8'h05, 1'b0, "ack_addr_r");
  endtask

  task automatic read_data(input logic mack);
    logic [7:0] got;
    logic [7:0] exp;
    logic       b;
    rd_q.push_back(model[mptr]);
    mptr = mptr + 8'd1;
    for (int i = 7; i >= 0; i--) begin
      get_bit(b);
      got[i] = b;
    end
    put_bit(mack);
    exp = (rd_q.size() > 0) ? rd_q.pop_front() : ~got;
    chk("read_byte", {24'd0, got}, {24'd0, exp});
  endtask

  initial begin
    for (int i = 0; i < 256; i++) model[i] = 8'h00;
    mptr = 8'h00;

    // Reset
    tick(10);
    chk("rst_sda_released", {31'd0, sda_bus}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_wr_strobe", {31'd0, wr_strobe}, 32'd0);
    reset = 1'b1;
    tick(10);

    // Read at pointer 0 straight after reset
    read_start();
    chk("busy_on_match", {31'd0, busy}, 32'd1);
    read_data(1'b1);
    stop_c();
    chk("busy_after_stop", {31'd0, busy}, 32'd0);

    // Write 0xA5 at 0x2F, then read at the incremented pointer (0x30)
    set_ptr(8'h2F);
    write_data(8'hA5);
    stop_c();
    read_start();
    read_data(1'b1);
    stop_c();

    // Pointer-only write, then a repeated START into a read
    set_ptr(8'h2F);
    read_start();
    read_data(1'b1);
    chk("sda_released_after_nack", {31'd0, sda_bus}, 32'd1);
    stop_c();

    // Wrong address: no ACK, no write, busy stays low
    start_c();
    send_byte(8'h0C, 1'b1, "nack_wrong_addr");
    chk("busy_wrong_addr", {31'd0, busy}, 32'd0);
    send_byte(8'h11, 1'b1, "nack_ignored_byte");
    stop_c();
    chk("busy_after_wrong", {31'd0, busy}, 32'd0);

    // Wrap and burst, for writes and reads
    set_ptr(8'hFF);
    write_data(8'h12);
    write_data(8'h34);
    stop_c();
    set_ptr(8'hFF);
    read_start();
    read_data(1'b0);
    read_data(1'b1);
    stop_c();

    // Abort: reset while the target holds SDA low (bit 7 of 0x12)
    set_ptr(8'hFF);
    read_start();
    chk("target_drives_low", {31'd0, sda_bus}, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("abort_sda_released", {31'd0, sda_bus}, 32'd1);
    tick(10);
    scl_m = 1'b1; sda_m = 1'b1;
    for (int i = 0; i < 256; i++) model[i] = 8'h00;
    mptr = 8'h00;
    tick(5);
    reset = 1'b1;
    tick(20);
    set_ptr(8'hFF);
    read_start();
    read_data(1'b1);
    stop_c();

    tick(20);
    chk("wr_q_drained", wr_q.size(), 32'd0);
    chk("rd_q_drained", rd_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
